// File: rtl/fibonacci_param.sv
// Iterative Fibonacci/Lucas term generator with carry-tracked overflow; n+1 cycles accept-to-result.
// One request at a time; result held until out_ready. Define FIB_SATURATE_EN for saturating sums.
module fibonacci_param #(
   parameter int DW = 16,
   parameter int LW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [LW-1:0] in_level,
   input  logic          in_mode,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] result,
   output logic          overflow
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t        state;
   state_t        state_nxt;
   logic [DW-1:0] a;
   logic [DW-1:0] b;
   logic [LW-1:0] cnt;
   logic          ovf_a;
   logic          ovf_b;
   logic [DW:0]   sum;
   logic          ovf_nxt;
   logic [DW-1:0] b_nxt;

   assign sum     = {1'b0, a} + {1'b0, b};
   // Once any term has overflowed, every later term is also out of range.
   assign ovf_nxt = ovf_a | ovf_b | sum[DW];

`ifdef FIB_SATURATE_EN
   assign b_nxt = ovf_nxt ? {DW{1'b1}} : sum[DW-1:0];
`else
   assign b_nxt = sum[DW-1:0];
`endif

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid)      state_nxt = CALC;
         CALC:    if (cnt == '0)     state_nxt = DONE;
         DONE:    if (out_ready)     state_nxt = IDLE;
         default:                    state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a        <= '0;
         b        <= '0;
         cnt      <= '0;
         ovf_a    <= 1'b0;
         ovf_b    <= 1'b0;
         result   <= '0;
         overflow <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a     <= in_mode ? DW'(2) : DW'(0);
                  b     <= DW'(1);
                  cnt   <= in_level;
                  ovf_a <= 1'b0;
                  ovf_b <= 1'b0;
               end
            end
            CALC: begin
               if (cnt != '0) begin
                  a     <= b;
                  b     <= b_nxt;
                  cnt   <= cnt - 1'b1;
                  ovf_a <= ovf_b;
                  ovf_b <= ovf_nxt;
               end else begin
                  // Only term n (in a) is reported; b's flag belongs to term n+1.
                  result   <= a;
                  overflow <= ovf_a;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fibonacci_param.sv
// Directed bench for fibonacci_param at DW=8, LW=8: latency, overflow, hold, reset abort, back-to-back.
module tb_fibonacci_param;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_level;
   logic       in_mode;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] result;
   logic       overflow;

   int total = 0;
   int bad   = 0;

   fibonacci_param #(.DW(8), .LW(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_level(in_level), .in_mode(in_mode),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic issue(input logic [7:0] n, input logic m);
      chk("in_ready_idle", {31'd0, in_ready}, 1);
      in_level = n;
      in_mode  = m;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      in_mode  = ~m;
      in_level = 8'hAA;
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      while (!out_valid && lat < 400) begin
         @(posedge clk);
         @(negedge clk);
         lat++;
      end
      if (!out_valid) chk("timeout", {31'd0, out_valid}, 1);
   endtask

   task automatic ack();
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      chk("valid_after_ack", {31'd0, out_valid}, 0);
   endtask

   function automatic longint seq_term(input int n, input logic m);
      longint x, y, t;
      x = m ? 2 : 0;
      y = 1;
      for (int i = 0; i < n; i++) begin
         t = x + y;
         x = y;
         y = t;
      end
      return x;
   endfunction

   task automatic run_one(input logic [7:0] n, input logic m, input int exp_r, input int exp_o);
      int lat;
      issue(n, m);
      wait_done(lat);
      chk("latency", lat, int'(n) + 1);
      chk("result", {24'd0, result}, exp_r);
      chk("overflow", {31'd0, overflow}, exp_o);
      ack();
   endtask

   initial begin
      int     lat;
      int     seen;
      int     n;
      logic   m;
      longint v;
      int     er;
      int     sat_r;

`ifdef FIB_SATURATE_EN
      sat_r = 255;
`else
      sat_r = 121;
`endif

      rst_n = 1'b0; in_valid = 1'b0; in_level = '0; in_mode = 1'b0; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_out_valid", {31'd0, out_valid}, 0);
      chk("rst_result", {24'd0, result}, 0);
      chk("rst_overflow", {31'd0, overflow}, 0);
      rst_n = 1'b1;

      run_one(8'd10, 1'b0, 55, 0);
      run_one(8'd13, 1'b0, 233, 0);
      run_one(8'd14, 1'b0, sat_r, 1);
      run_one(8'd5, 1'b1, 11, 0);
      run_one(8'd0, 1'b1, 2, 0);
      run_one(8'd0, 1'b0, 0, 0);

      // Result hold under backpressure; requests in CALC/DONE are dropped.
      issue(8'd3, 1'b0);
      in_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      chk("busy_in_ready", {31'd0, in_ready}, 0);
      in_valid = 1'b0;
      wait_done(lat);
      for (int i = 0; i < 4; i++) begin
         chk("hold_valid", {31'd0, out_valid}, 1);
         chk("hold_result", {24'd0, result}, 2);
         chk("hold_in_ready", {31'd0, in_ready}, 0);
         in_valid = ~in_valid;
         @(posedge clk); @(negedge clk);
      end
      in_valid = 1'b0;
      chk("hold_result_end", {24'd0, result}, 2);
      ack();
      seen = 0;
      repeat (3) begin
         @(posedge clk); @(negedge clk);
         if (out_valid || !in_ready) seen++;
      end
      chk("dropped_reqs", seen, 0);

      // Reset abort mid-computation.
      issue(8'd12, 1'b0);
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_out_valid", {31'd0, out_valid}, 0);
      chk("abort_result", {24'd0, result}, 0);
      chk("abort_overflow", {31'd0, overflow}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (20) begin
         @(posedge clk); @(negedge clk);
         if (out_valid) seen++;
      end
      chk("no_valid_after_abort", seen, 0);
      run_one(8'd4, 1'b0, 3, 0);

      // Back-to-back with out_ready tied high.
      out_ready = 1'b1;
      for (int k = 0; k < 20; k++) begin
         n = $urandom_range(0, 13);
         m = 1'($urandom_range(0, 1));
         v = seq_term(n, m);
         if (v > 255) er = sat_r == 255 ? 255 : int'(v % 256);
         else         er = int'(v);
         issue(8'(n), m);
         wait_done(lat);
         chk("b2b_latency", lat, n + 1);
         chk("b2b_result", {24'd0, result}, er);
         chk("b2b_overflow", {31'd0, overflow}, (v > 255) ? 1 : 0);
         @(posedge clk); @(negedge clk);
         chk("b2b_handshake", {31'd0, out_valid}, 0);
      end
      out_ready = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule

// File: doc/fibonacci_param.md
FIBONACCI_PARAM -- requirements
Module: fibonacci_param

Interface
REQ-001 Parameter DW, default 16, result/datapath width in bits (DW >= 4).
REQ-002 Parameter LW, default 8, width of the requested sequence index.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 in_level  input  LW  sequence index n.
REQ-008 in_mode  input  1  0 = Fibonacci (seeds 0,1); 1 = Lucas (seeds 2,1).
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 result  output  DW  term n of the selected sequence.
REQ-012 overflow  output  1  true term n exceeds 2^DW-1; valid with out_valid.

Function
REQ-013 The FSM SHALL have three states: IDLE, CALC and DONE.
REQ-014 IDLE: in_ready=1; in_valid high at an edge accepts the request; in_level and in_mode are latched; a=seed0, b=seed1, cnt=in_level; the FSM goes to CALC.
REQ-015 CALC: cnt!=0 -> a<=b, b<=a+b, cnt<=cnt-1; cnt==0 -> result<=a, overflow<=ovf_a, go to DONE.
REQ-016 Latency SHALL be n+1 cycles from the accepting edge to out_valid high; n=0 gives 1 cycle with result=seed0.
REQ-017 DONE: out_valid=1; result and overflow SHALL stay stable until an edge with out_ready=1, then the FSM returns to IDLE.
REQ-018 in_ready SHALL be 0 in CALC and DONE; in_valid there is ignored and not queued.
REQ-019 No bypass: a new request SHALL be accepted no earlier than the edge after the out_valid&out_ready handshake.
REQ-020 Overflow tracking: ovf_a/ovf_b flags shadow a/b; new ovf_b = ovf_a | ovf_b | carry-out of a+b; ovf_a<=ovf_b on each step; flags clear at accept.
REQ-021 overflow SHALL reflect only term n; an overflow of term n+1 held in b SHALL NOT set it.
REQ-022 in_mode latched at accept; later in_mode changes SHALL NOT affect the computation in flight.
REQ-023 All arithmetic SHALL be unsigned, DW bits, plus the carry bit.

Reset
REQ-024 rst_n low SHALL immediately force IDLE, in_ready=1 (after release), out_valid=0, result=0, overflow=0, a=b=cnt=0, all flags 0.
REQ-025 Reset asserted in CALC or DONE SHALL abandon the request; no out_valid SHALL follow.
REQ-026 The first request SHALL be accepted at the first edge after rst_n deasserts.

Configuration
REQ-027 Macro FIB_SATURATE_EN defined: when an addition overflows, b SHALL load 2^DW-1 and stay saturated; the result for an overflowed term is 2^DW-1.
REQ-028 FIB_SATURATE_EN undefined: the sum SHALL wrap modulo 2^DW; the overflow output and its tracking are identical in both builds.

Verification (DW=8, LW=8)
REQ-029 Fibonacci n=10 -> result 55, overflow 0, out_valid 11 cycles after accept.
REQ-030 Fibonacci n=13 -> 233, overflow 0 (F14=377 in b SHALL NOT flag); n=14 -> overflow 1, result 121 without the macro, 255 with FIB_SATURATE_EN.
REQ-031 Lucas n=5 -> 11; Lucas n=0 -> 2 after 1 cycle; Fibonacci n=0 -> 0.
REQ-032 n=3, out_ready held 0 for 4 cycles after out_valid -> result 2 stable; in_ready 0 throughout; in_valid pulses in that window are dropped.
REQ-033 Reset pulse in mid-CALC of n=12 -> outputs 0 immediately; no out_valid; next request n=4 -> 3.
REQ-034 Back-to-back requests with out_ready tied 1 -> each accepted one cycle after the prior handshake; 20 random n in 0..13 checked against a model.
